wb_dual_master_arbiter: RTL and testbench

WB_DUAL_MASTER_ARBITER -- requirements
Module: wb_dual_master_arbiter

---
 rtl/wb_dual_master_arbiter_pkg.sv | 27 ++
 rtl/wb_dual_master_arbiter_if.sv | 21 ++
 rtl/wb_dual_master_arbiter_addr_decoder.sv | 26 ++
 rtl/wb_dual_master_arbiter.sv | 163 ++++++++++++++++
 tb/tb_wb_dual_master_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/wb_dual_master_arbiter_pkg.sv
// Shared types and constants for the dual-initiator Wishbone arbiter:
// FSM state encoding, target indices and default address decode values.
package wb_dual_master_arbiter_pkg;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 4;
    localparam int CNT_W   = 16;
    localparam int NUM_TGT = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        TGT_SRAM = 2'd0,
        TGT_UART = 2'd1,
        TGT_ETH  = 2'd2
    } tgt_e;

    localparam logic [7:0] DEF_SRAM_ADDR = 8'h00;
    localparam logic [7:0] DEF_UART_ADDR = 8'h90;
    localparam logic [7:0] DEF_ETH_ADDR  = 8'h92;

endpackage

// File: rtl/wb_dual_master_arbiter_if.sv
// One Wishbone point-to-point link. Handshake: a transfer is offered while
// cyc and stb are high and completes in the cycle the responder raises ack
// (success) or err (failure); the initiator holds adr/dat_w/sel/we stable
// until then. The "master" modport is the initiator side, "slave" the target.
interface wb_dual_master_arbiter_if;
    import wb_dual_master_arbiter_pkg::*;

    logic              cyc;
    logic              stb;
    logic              we;
    logic [ADDR_W-1:0] adr;
    logic [DATA_W-1:0] dat_w;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] dat_r;
    logic              ack;
    logic              err;

    modport master (output cyc, stb, we, adr, dat_w, sel, input dat_r, ack, err);
    modport slave  (input cyc, stb, we, adr, dat_w, sel, output dat_r, ack, err);

endinterface

// File: rtl/wb_dual_master_arbiter_addr_decoder.sv
// Combinational address decoder: maps the top address bits to a target
// index and flags addresses that match no target.
module wb_addr_decoder
    import wb_dual_master_arbiter_pkg::*;
#(
    parameter int                    ADDR_DEC_W = 8,
    parameter logic [ADDR_DEC_W-1:0] SRAM_ADDR  = ADDR_DEC_W'(DEF_SRAM_ADDR),
    parameter logic [ADDR_DEC_W-1:0] UART_ADDR  = ADDR_DEC_W'(DEF_UART_ADDR),
    parameter logic [ADDR_DEC_W-1:0] ETH_ADDR   = ADDR_DEC_W'(DEF_ETH_ADDR)
) (
    input  logic [ADDR_DEC_W-1:0] adr_msb,
    output tgt_e                  tgt,
    output logic                  unmapped
);

    // Compare the decode field against each target's base value.
    always_comb begin
        tgt      = TGT_SRAM;
        unmapped = 1'b0;
        if (adr_msb == SRAM_ADDR)      tgt = TGT_SRAM;
        else if (adr_msb == UART_ADDR) tgt = TGT_UART;
        else if (adr_msb == ETH_ADDR)  tgt = TGT_ETH;
        else                           unmapped = 1'b1;
    end

endmodule

// File: rtl/wb_dual_master_arbiter.sv
// Two-initiator, three-target Wishbone arbiter with round-robin ownership,
// address decode, unmapped-address error and a stuck-target timeout.
module wb_dual_master_arbiter
    import wb_dual_master_arbiter_pkg::*;
#(
    parameter int                    TIMEOUT_CYCLES = 255,
    parameter int                    ADDR_DEC_W     = 8,
    parameter logic [ADDR_DEC_W-1:0] SRAM_ADDR      = ADDR_DEC_W'(DEF_SRAM_ADDR),
    parameter logic [ADDR_DEC_W-1:0] UART_ADDR      = ADDR_DEC_W'(DEF_UART_ADDR),
    parameter logic [ADDR_DEC_W-1:0] ETH_ADDR       = ADDR_DEC_W'(DEF_ETH_ADDR)
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    wb_dual_master_arbiter_if.slave  m0_wb,
    wb_dual_master_arbiter_if.slave  m1_wb,
    wb_dual_master_arbiter_if.master s0_wb,
    wb_dual_master_arbiter_if.master s1_wb,
    wb_dual_master_arbiter_if.master s2_wb,
    output logic [1:0]               grant_o,
    output logic                     timeout_o
);

    arb_state_e        state, state_next;
    logic              last_owner, last_owner_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              unm_err, unm_err_next;

    logic              own_cyc, own_stb, own_we;
    logic [ADDR_W-1:0] own_adr;
    logic [DATA_W-1:0] own_dat;
    logic [SEL_W-1:0]  own_sel;

    tgt_e              tgt;
    logic              unmapped;
    logic              owner_active, sel_hit, timeout_hit;
    logic [NUM_TGT-1:0] t_en;
    logic [DATA_W-1:0] rsp_dat;
    logic              rsp_ack, rsp_err, m_ack, m_err;

    // State, round-robin owner, timeout counter and unmapped-error flag.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state      <= ST_IDLE;
            last_owner <= 1'b1;
            cnt        <= '0;
            unm_err    <= 1'b0;
        end else begin
            state      <= state_next;
            last_owner <= last_owner_next;
            cnt        <= cnt_next;
            unm_err    <= unm_err_next;
        end
    end

    // Arbitration: grant from IDLE only, release back to IDLE on cyc drop.
    always_comb begin
        state_next      = state;
        last_owner_next = last_owner;
        case (state)
            ST_IDLE: begin
                if (m0_wb.cyc && m1_wb.cyc) state_next = last_owner ? ST_OWN0 : ST_OWN1;
                else if (m0_wb.cyc)         state_next = ST_OWN0;
                else if (m1_wb.cyc)         state_next = ST_OWN1;
            end
            ST_OWN0: if (!m0_wb.cyc) begin state_next = ST_IDLE; last_owner_next = 1'b0; end
            ST_OWN1: if (!m1_wb.cyc) begin state_next = ST_IDLE; last_owner_next = 1'b1; end
            default: state_next = ST_IDLE;
        endcase
    end

    // Select the current owner's request signals; zero when idle.
    always_comb begin
        own_cyc = 1'b0; own_stb = 1'b0; own_we = 1'b0;
        own_adr = '0;   own_dat = '0;   own_sel = '0;
        case (state)
            ST_OWN0: begin
                own_cyc = m0_wb.cyc; own_stb = m0_wb.stb; own_we  = m0_wb.we;
                own_adr = m0_wb.adr; own_dat = m0_wb.dat_w; own_sel = m0_wb.sel;
            end
            ST_OWN1: begin
                own_cyc = m1_wb.cyc; own_stb = m1_wb.stb; own_we  = m1_wb.we;
                own_adr = m1_wb.adr; own_dat = m1_wb.dat_w; own_sel = m1_wb.sel;
            end
            default: ;
        endcase
    end

    wb_addr_decoder #(
        .ADDR_DEC_W (ADDR_DEC_W),
        .SRAM_ADDR  (SRAM_ADDR),
        .UART_ADDR  (UART_ADDR),
        .ETH_ADDR   (ETH_ADDR)
    ) u_dec (
        .adr_msb  (own_adr[ADDR_W-1 -: ADDR_DEC_W]),
        .tgt      (tgt),
        .unmapped (unmapped)
    );

    assign owner_active = (state != ST_IDLE);
    assign sel_hit      = owner_active && !unmapped;
    // The timeout fires on the counter value alone so the forced stb drop
    // never depends on the target's own response in the same cycle.
    assign timeout_hit  = sel_hit && own_stb && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign t_en         = sel_hit ? (NUM_TGT'(1) << tgt) : '0;

    assign s0_wb.cyc   = t_en[0] & own_cyc;
    assign s0_wb.stb   = t_en[0] & own_stb & ~timeout_hit;
    assign s0_wb.we    = t_en[0] & own_we;
    assign s0_wb.adr   = t_en[0] ? own_adr : '0;
    assign s0_wb.dat_w = t_en[0] ? own_dat : '0;
    assign s0_wb.sel   = t_en[0] ? own_sel : '0;

    assign s1_wb.cyc   = t_en[1] & own_cyc;
    assign s1_wb.stb   = t_en[1] & own_stb & ~timeout_hit;
    assign s1_wb.we    = t_en[1] & own_we;
    assign s1_wb.adr   = t_en[1] ? own_adr : '0;
    assign s1_wb.dat_w = t_en[1] ? own_dat : '0;
    assign s1_wb.sel   = t_en[1] ? own_sel : '0;

    assign s2_wb.cyc   = t_en[2] & own_cyc;
    assign s2_wb.stb   = t_en[2] & own_stb & ~timeout_hit;
    assign s2_wb.we    = t_en[2] & own_we;
    assign s2_wb.adr   = t_en[2] ? own_adr : '0;
    assign s2_wb.dat_w = t_en[2] ? own_dat : '0;
    assign s2_wb.sel   = t_en[2] ? own_sel : '0;

    // Pick the response of the selected target; nothing when idle or unmapped.
    always_comb begin
        rsp_dat = '0; rsp_ack = 1'b0; rsp_err = 1'b0;
        if (sel_hit) begin
            case (tgt)
                TGT_SRAM: begin rsp_dat = s0_wb.dat_r; rsp_ack = s0_wb.ack; rsp_err = s0_wb.err; end
                TGT_UART: begin rsp_dat = s1_wb.dat_r; rsp_ack = s1_wb.ack; rsp_err = s1_wb.err; end
                TGT_ETH:  begin rsp_dat = s2_wb.dat_r; rsp_ack = s2_wb.ack; rsp_err = s2_wb.err; end
                default: ;
            endcase
        end
    end

    // Error takes priority over ack whenever both would be reported.
    assign m_err = timeout_hit | unm_err | rsp_err;
    assign m_ack = rsp_ack & ~m_err;

    assign m0_wb.dat_r = (state == ST_OWN0) ? rsp_dat : '0;
    assign m0_wb.ack   = (state == ST_OWN0) & m_ack;
    assign m0_wb.err   = (state == ST_OWN0) & m_err;
    assign m1_wb.dat_r = (state == ST_OWN1) ? rsp_dat : '0;
    assign m1_wb.ack   = (state == ST_OWN1) & m_ack;
    assign m1_wb.err   = (state == ST_OWN1) & m_err;

    assign grant_o   = {state == ST_OWN1, state == ST_OWN0};
    assign timeout_o = timeout_hit;

    // Wait counter and unmapped-error toggle; both restart on ownership change.
    always_comb begin
        if ((state_next != state) || !sel_hit || !own_stb || rsp_ack || rsp_err || timeout_hit)
            cnt_next = '0;
        else
            cnt_next = cnt + CNT_W'(1);
        unm_err_next = owner_active && (state_next == state) && own_stb && unmapped && !unm_err;
    end

endmodule

// File: tb/tb_wb_dual_master_arbiter.sv
// Directed self-checking bench for wb_dual_master_arbiter.
module tb_wb_dual_master_arbiter;

    logic       wb_clk_i = 1'b0;
    logic       wb_rst_i;
    logic [1:0] grant_o;
    logic       timeout_o;
    int         checks = 0;
    int         fails  = 0;

    wb_dual_master_arbiter_if m0_wb();
    wb_dual_master_arbiter_if m1_wb();
    wb_dual_master_arbiter_if s0_wb();
    wb_dual_master_arbiter_if s1_wb();
    wb_dual_master_arbiter_if s2_wb();

    wb_dual_master_arbiter #(.TIMEOUT_CYCLES(4)) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_i  (wb_rst_i),
        .m0_wb     (m0_wb),
        .m1_wb     (m1_wb),
        .s0_wb     (s0_wb),
        .s1_wb     (s1_wb),
        .s2_wb     (s2_wb),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    // Clock generation.
    always #5 wb_clk_i = ~wb_clk_i;

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic idle_bus();
        m0_wb.cyc = 0; m0_wb.stb = 0; m0_wb.we = 0; m0_wb.adr = 0; m0_wb.dat_w = 0; m0_wb.sel = 0;
        m1_wb.cyc = 0; m1_wb.stb = 0; m1_wb.we = 0; m1_wb.adr = 0; m1_wb.dat_w = 0; m1_wb.sel = 0;
        s0_wb.dat_r = 0; s0_wb.ack = 0; s0_wb.err = 0;
        s1_wb.dat_r = 0; s1_wb.ack = 0; s1_wb.err = 0;
        s2_wb.dat_r = 0; s2_wb.ack = 0; s2_wb.err = 0;
    endtask

    task automatic apply_reset();
        wb_rst_i = 1'b1;
        repeat (2) next_cycle();
        wb_rst_i = 1'b0;
    endtask

    task automatic test_reset();
        wb_rst_i = 1'b1;
        idle_bus();
        m0_wb.cyc = 1; m0_wb.stb = 1; s0_wb.ack = 1; s0_wb.dat_r = 32'hFFFF_FFFF;
        repeat (2) next_cycle();
        #1;
        checks++; if (grant_o !== 2'b00) begin fails++; $display("FAIL rst_grant: got %b want 00", grant_o); end
        checks++; if (s0_wb.cyc !== 1'b0 || s0_wb.stb !== 1'b0) begin fails++; $display("FAIL rst_s0: got cyc=%b stb=%b want 0 0", s0_wb.cyc, s0_wb.stb); end
        checks++; if (m0_wb.ack !== 1'b0 || m0_wb.dat_r !== 32'h0) begin fails++; $display("FAIL rst_m0: got ack=%b dat=%h want 0 0", m0_wb.ack, m0_wb.dat_r); end
        checks++; if (timeout_o !== 1'b0) begin fails++; $display("FAIL rst_timeout: got %b want 0", timeout_o); end
        idle_bus();
        next_cycle();
        wb_rst_i = 1'b0;
    endtask

    task automatic test_sram_read();
        next_cycle();
        m0_wb.cyc = 1; m0_wb.stb = 1; m0_wb.we = 0; m0_wb.adr = 32'h0000_0010; m0_wb.sel = 4'hF;
        #1;
        checks++; if (grant_o !== 2'b00) begin fails++; $display("FAIL rd_latency_grant: got %b want 00", grant_o); end
        checks++; if (s0_wb.cyc !== 1'b0) begin fails++; $display("FAIL rd_latency_s0: got %b want 0", s0_wb.cyc); end
        next_cycle();
        #1;
        checks++; if (grant_o !== 2'b01) begin fails++; $display("FAIL rd_grant: got %b want 01", grant_o); end
        checks++; if (s0_wb.stb !== 1'b1 || s0_wb.adr !== 32'h0000_0010) begin fails++; $display("FAIL rd_s0_req: got stb=%b adr=%h want 1 00000010", s0_wb.stb, s0_wb.adr); end
        checks++; if (m0_wb.ack !== 1'b0) begin fails++; $display("FAIL rd_early_ack: got %b want 0", m0_wb.ack); end
        next_cycle();
        s0_wb.ack = 1; s0_wb.dat_r = 32'hDEAD_BEEF;
        #1;
        checks++; if (m0_wb.ack !== 1'b1 || m0_wb.dat_r !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_m0_resp: got ack=%b dat=%h want 1 deadbeef", m0_wb.ack, m0_wb.dat_r); end
        checks++; if (m1_wb.ack !== 1'b0 || m1_wb.err !== 1'b0 || m1_wb.dat_r !== 32'h0) begin fails++; $display("FAIL rd_m1_quiet: got ack=%b err=%b dat=%h want 0 0 0", m1_wb.ack, m1_wb.err, m1_wb.dat_r); end
        next_cycle();
        idle_bus();
        next_cycle();
        #1;
        checks++; if (grant_o !== 2'b00) begin fails++; $display("FAIL rd_release: got %b want 00", grant_o); end
    endtask

    task automatic test_ack_err_collision();
        next_cycle();
        m0_wb.cyc = 1; m0_wb.stb = 1; m0_wb.adr = 32'h0000_0100;
        next_cycle();
        s1_wb.ack = 1;
        #1;
        checks++; if (m0_wb.ack !== 1'b0 || m0_wb.err !== 1'b0) begin fails++; $display("FAIL col_foreign_ack: got ack=%b err=%b want 0 0", m0_wb.ack, m0_wb.err); end
        next_cycle();
        s1_wb.ack = 0; s0_wb.ack = 1; s0_wb.err = 1;
        #1;
        checks++; if (m0_wb.err !== 1'b1 || m0_wb.ack !== 1'b0) begin fails++; $display("FAIL col_err_wins: got ack=%b err=%b want 0 1", m0_wb.ack, m0_wb.err); end
        next_cycle();
        idle_bus();
        next_cycle();
    endtask

    task automatic test_round_robin();
        apply_reset();
        m0_wb.cyc = 1; m1_wb.cyc = 1;
        #1;
        checks++; if (grant_o !== 2'b00) begin fails++; $display("FAIL rr_idle: got %b want 00", grant_o); end
        next_cycle();
        #1;
        checks++; if (grant_o !== 2'b01) begin fails++; $display("FAIL rr_first_tie: got %b want 01", grant_o); end
        m0_wb.cyc = 0;
        next_cycle();
        #1;
        checks++; if (grant_o !== 2'b00) begin fails++; $display("FAIL rr_gap: got %b want 00", grant_o); end
        m0_wb.cyc = 1;
        next_cycle();
        #1;
        checks++; if (grant_o !== 2'b10) begin fails++; $display("FAIL rr_second_tie: got %b want 10", grant_o); end
        idle_bus();
        next_cycle();
        #1;
        checks++; if (grant_o !== 2'b00) begin fails++; $display("FAIL rr_release: got %b want 00", grant_o); end
    endtask

    task automatic test_uart_write();
        next_cycle();
        m1_wb.cyc = 1; m1_wb.stb = 1; m1_wb.we = 1; m1_wb.adr = 32'h9000_0004;
        m1_wb.dat_w = 32'h1234_5678; m1_wb.sel = 4'hF;
        next_cycle();
        #1;
        checks++; if (grant_o !== 2'b10) begin fails++; $display("FAIL wr_grant: got %b want 10", grant_o); end
        checks++; if (s1_wb.cyc !== 1'b1 || s1_wb.stb !== 1'b1 || s1_wb.we !== 1'b1) begin fails++; $display("FAIL wr_s1_ctl: got cyc=%b stb=%b we=%b want 1 1 1", s1_wb.cyc, s1_wb.stb, s1_wb.we); end
        checks++; if (s1_wb.adr !== 32'h9000_0004 || s1_wb.dat_w !== 32'h1234_5678 || s1_wb.sel !== 4'hF) begin fails++; $display("FAIL wr_s1_data: got adr=%h dat=%h sel=%h want 90000004 12345678 f", s1_wb.adr, s1_wb.dat_w, s1_wb.sel); end
        checks++; if (s0_wb.cyc !== 1'b0 || s0_wb.stb !== 1'b0 || s0_wb.adr !== 32'h0 || s0_wb.dat_w !== 32'h0) begin fails++; $display("FAIL wr_s0_zero: got cyc=%b stb=%b adr=%h dat=%h want all 0", s0_wb.cyc, s0_wb.stb, s0_wb.adr, s0_wb.dat_w); end
        checks++; if (s2_wb.cyc !== 1'b0 || s2_wb.stb !== 1'b0 || s2_wb.adr !== 32'h0 || s2_wb.dat_w !== 32'h0) begin fails++; $display("FAIL wr_s2_zero: got cyc=%b stb=%b adr=%h dat=%h want all 0", s2_wb.cyc, s2_wb.stb, s2_wb.adr, s2_wb.dat_w); end
        s1_wb.ack = 1;
        #1;
        checks++; if (m1_wb.ack !== 1'b1 || m0_wb.ack !== 1'b0) begin fails++; $display("FAIL wr_ack_route: got m1=%b m0=%b want 1 0", m1_wb.ack, m0_wb.ack); end
        next_cycle();
        idle_bus();
        next_cycle();
    endtask

    task automatic test_unmapped();
        next_cycle();
        m0_wb.cyc = 1; m0_wb.stb = 1; m0_wb.adr = 32'h5000_0000;
        next_cycle();
        #1;
        checks++; if ({s0_wb.stb, s1_wb.stb, s2_wb.stb} !== 3'b000) begin fails++; $display("FAIL unm_no_stb: got %b want 000", {s0_wb.stb, s1_wb.stb, s2_wb.stb}); end
        checks++; if (m0_wb.err !== 1'b0) begin fails++; $display("FAIL unm_err_early: got %b want 0", m0_wb.err); end
        next_cycle();
        #1;
        checks++; if (m0_wb.err !== 1'b1 || timeout_o !== 1'b0) begin fails++; $display("FAIL unm_err_pulse: got err=%b timeout=%b want 1 0", m0_wb.err, timeout_o); end
        next_cycle();
        #1;
        checks++; if (m0_wb.err !== 1'b0) begin fails++; $display("FAIL unm_err_gap: got %b want 0", m0_wb.err); end
        next_cycle();
        #1;
        checks++; if (m0_wb.err !== 1'b1) begin fails++; $display("FAIL unm_err_repeat: got %b want 1", m0_wb.err); end
        idle_bus();
        next_cycle();
        #1;
        checks++; if (m0_wb.err !== 1'b0 || grant_o !== 2'b00) begin fails++; $display("FAIL unm_release: got err=%b grant=%b want 0 00", m0_wb.err, grant_o); end
    endtask

    task automatic test_timeout();
        next_cycle();
        m0_wb.cyc = 1; m0_wb.stb = 1; m0_wb.adr = 32'h9200_0000;
        next_cycle();
        #1;
        checks++; if (s2_wb.stb !== 1'b1 || m0_wb.err !== 1'b0 || timeout_o !== 1'b0) begin fails++; $display("FAIL to_wait1: got stb=%b err=%b to=%b want 1 0 0", s2_wb.stb, m0_wb.err, timeout_o); end
        next_cycle();
        next_cycle();
        #1;
        checks++; if (m0_wb.err !== 1'b0 || timeout_o !== 1'b0) begin fails++; $display("FAIL to_wait3: got err=%b to=%b want 0 0", m0_wb.err, timeout_o); end
        next_cycle();
        #1;
        checks++; if (m0_wb.err !== 1'b1 || timeout_o !== 1'b1) begin fails++; $display("FAIL to_fire: got err=%b to=%b want 1 1", m0_wb.err, timeout_o); end
        checks++; if (s2_wb.stb !== 1'b0 || s2_wb.cyc !== 1'b1) begin fails++; $display("FAIL to_stb_drop: got stb=%b cyc=%b want 0 1", s2_wb.stb, s2_wb.cyc); end
        next_cycle();
        #1;
        checks++; if (timeout_o !== 1'b0 || s2_wb.stb !== 1'b1) begin fails++; $display("FAIL to_restart: got to=%b stb=%b want 0 1", timeout_o, s2_wb.stb); end
        idle_bus();
        repeat (2) next_cycle();
    endtask

    task automatic test_async_reset();
        next_cycle();
        m1_wb.cyc = 1; m1_wb.stb = 1; m1_wb.adr = 32'h9200_0000;
        next_cycle();
        #1;
        checks++; if (grant_o !== 2'b10) begin fails++; $display("FAIL ar_owner: got %b want 10", grant_o); end
        #2;
        wb_rst_i = 1'b1;
        #1;
        checks++; if (grant_o !== 2'b00) begin fails++; $display("FAIL ar_grant: got %b want 00", grant_o); end
        checks++; if (s2_wb.cyc !== 1'b0 || s2_wb.stb !== 1'b0 || s2_wb.adr !== 32'h0) begin fails++; $display("FAIL ar_s2: got cyc=%b stb=%b adr=%h want 0 0 0", s2_wb.cyc, s2_wb.stb, s2_wb.adr); end
        checks++; if (m1_wb.err !== 1'b0 || timeout_o !== 1'b0) begin fails++; $display("FAIL ar_m1: got err=%b to=%b want 0 0", m1_wb.err, timeout_o); end
        m0_wb.cyc = 1;
        repeat (2) next_cycle();
        wb_rst_i = 1'b0;
        #1;
        checks++; if (m1_wb.err !== 1'b0 || m1_wb.ack !== 1'b0 || grant_o !== 2'b00) begin fails++; $display("FAIL ar_release: got err=%b ack=%b grant=%b want 0 0 00", m1_wb.err, m1_wb.ack, grant_o); end
        next_cycle();
        #1;
        checks++; if (grant_o !== 2'b01) begin fails++; $display("FAIL ar_tie_after: got %b want 01", grant_o); end
        idle_bus();
        repeat (2) next_cycle();
    endtask

    // Test sequence.
    initial begin
        test_reset();
        test_sram_read();
        test_ack_err_collision();
        test_round_robin();
        test_uart_write();
        test_unmapped();
        test_timeout();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
